// File: rtl/dice_roll_gen.sv
// dice_roll_gen
// -------------
// Upstream stage of the dual-dice game controller. It cleans up the roll
// push-button and spins two dice while the button is held. On release it
// freezes the dice and presents their sum with a one-cycle rb pulse.
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst      - synchronous, active-high reset
//   btn_raw  - asynchronous, bouncy push-button, active-high
//   rb       - one-cycle pulse; sum is valid and stable in this cycle
//   sum      - die_a + die_b (2..12), held until the next settle; 0 after reset
//   die_a    - first die value, 1..6
//   die_b    - second die value, 1..6
//   busy     - high while a roll is in progress (spin, settle, present)
//   roll_cnt - number of completed rolls, wraps modulo 2^CNT_W
//
// Optional build macro: DICE_LFSR_MIX_EN
//   When defined, a free-running 16-bit LFSR decides in which spin cycles
//   die_b advances. When undefined, die_b advances each time die_a wraps
//   from 6 to 1. The port list is the same in both builds.

module dice_roll_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_SPIN        = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  output logic             rb,
  output logic [3:0]       sum,
  output logic [2:0]       die_a,
  output logic [2:0]       die_b,
  output logic             busy,
  output logic [CNT_W-1:0] roll_cnt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SP_W = $clog2(MIN_SPIN + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPIN    = 2'd1,
    SETTLE  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t          state;
  logic            sync1;
  logic            btn_s;
  logic            btn_db;
  logic            btn_db_d;
  logic [DB_W-1:0] db_cnt;
  logic [SP_W-1:0] spin_cnt;
  logic            press;
  logic            die_b_step;
  logic            spin_done;

  // The button is asynchronous to clk. It goes through two flops before
  // anything else looks at it, so metastability cannot reach the rest of
  // the logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
    end
  end

  // Debouncer. The debounced level only flips after the synchronised
  // button has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
  // Any agreement restarts the count, so short bounces are swallowed.
  // btn_db_d is kept here as well so the edge detector has the previous level.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= ~btn_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press     = btn_db & ~btn_db_d;
  assign spin_done = (spin_cnt >= SP_W'(MIN_SPIN)) && !btn_db;

`ifdef DICE_LFSR_MIX_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR (taps 16,14,13,11). It steps every cycle,
  // including in IDLE, so the exact moment of a press changes the outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // In this build the LFSR picks which spin cycles move die_b.
  always_comb begin
    die_b_step = lfsr[0];
  end
`else
  // die_b behaves like the tens digit of a counter: it moves one step
  // in the cycle where die_a rolls over from 6 back to 1.
  always_comb begin
    die_b_step = (die_a == 3'd6);
  end
`endif

  function automatic logic [2:0] next_face(input logic [2:0] face);
    return (face == 3'd6) ? 3'd1 : face + 3'd1;
  endfunction

  // Roll sequencer. All outputs are registered here.
  // In SPIN the exit test is made before advancing, so the cycle that
  // decides to leave does not move the dice. spin_cnt saturates at
  // MIN_SPIN, which guarantees the minimum spin and keeps the counter
  // bounded during a long hold.
  // A press that arrives during SETTLE or PRESENT is ignored. By the time
  // IDLE is reached, btn_db_d has caught up, so the edge is gone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      die_a    <= 3'd1;
      die_b    <= 3'd1;
      sum      <= 4'd0;
      rb       <= 1'b0;
      busy     <= 1'b0;
      roll_cnt <= '0;
      spin_cnt <= '0;
    end else begin
      rb <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            state    <= SPIN;
            spin_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        SPIN: begin
          if (spin_done) begin
            state <= SETTLE;
          end else begin
            die_a <= next_face(die_a);
            if (die_b_step) begin
              die_b <= next_face(die_b);
            end
            if (spin_cnt < SP_W'(MIN_SPIN)) begin
              spin_cnt <= spin_cnt + 1'b1;
            end
          end
        end
        SETTLE: begin
          sum      <= {1'b0, die_a} + {1'b0, die_b};
          rb       <= 1'b1;
          roll_cnt <= roll_cnt + 1'b1;
          state    <= PRESENT;
        end
        PRESENT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_gen.sv
// tb_dice_roll_gen
// ----------------
// Self-checking bench for dice_roll_gen. It has three parts:
//   - a table of single presses, each applied from reset;
//   - hand-written sequences for the multi-cycle corner cases;
//   - a randomised run checked against a roll-level model.
// The model works per roll. A clean press held for H cycles (H >= 4)
// gives max(8, H-1) advances. The dice then read as a two-digit base-6
// count of all advances made since reset.

module tb_dice_roll_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       rb;
  logic [3:0] sum;
  logic [2:0] die_a;
  logic [2:0] die_b;
  logic       busy;
  logic [7:0] roll_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    int high;
    int exp_rolls;
    int exp_a;
    int exp_b;
    int exp_sum;
  } vec_t;

  typedef struct {
    logic [3:0] sum;
    logic [2:0] a;
    logic [2:0] b;
  } rb_rec_t;

  vec_t    vecs[8];
  rb_rec_t rb_q[$];

  dice_roll_gen #(
    .DEBOUNCE_CYCLES(4),
    .MIN_SPIN(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .rb(rb),
    .sum(sum),
    .die_a(die_a),
    .die_b(die_b),
    .busy(busy),
    .roll_cnt(roll_cnt)
  );

  always #5 clk = ~clk;

  // Record every rb pulse together with the values presented alongside it.
  always @(negedge clk) begin
    if (rb === 1'b1) begin
      rb_q.push_back('{sum, die_a, die_b});
    end
  end

  // Stop a runaway simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst     = 1'b1;
    btn_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rb_q.delete();
  endtask

  task automatic applyStimulus(input int high, input int gap);
    btn_raw = 1'b1;
    repeat (high) @(negedge clk);
    btn_raw = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic checkDieB(input string name, input int actual, input int expected);
`ifdef DICE_LFSR_MIX_EN
    checkOutput({name, " in 1..6"}, int'(actual >= 1 && actual <= 6), 1);
`else
    checkOutput(name, actual, expected);
`endif
  endtask

  task automatic checkSum(input string name, input int actual, input int expected);
`ifdef DICE_LFSR_MIX_EN
    checkOutput({name, " in 2..12"}, int'(actual >= 2 && actual <= 12), 1);
`else
    checkOutput(name, actual, expected);
`endif
  endtask

  initial begin
    int n;
    int rolls;
    int high;
    int gap;
    int adv;
    int got;
    rb_rec_t rec;

    rst     = 1'b1;
    btn_raw = 1'b0;

    // Table of single presses from reset: {high cycles, rolls, a, b, sum}.
    vecs[0] = '{1,  0, 1, 1, 0};
    vecs[1] = '{3,  0, 1, 1, 0};
    vecs[2] = '{4,  1, 3, 2, 5};
    vecs[3] = '{6,  1, 3, 2, 5};
    vecs[4] = '{9,  1, 3, 2, 5};
    vecs[5] = '{10, 1, 4, 2, 6};
    vecs[6] = '{14, 1, 2, 3, 5};
    vecs[7] = '{20, 1, 2, 4, 6};

    // Reset state.
    doReset();
    checkOutput("reset die_a", int'(die_a), 1);
    checkOutput("reset die_b", int'(die_b), 1);
    checkOutput("reset sum", int'(sum), 0);
    checkOutput("reset rb", int'(rb), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset roll_cnt", int'(roll_cnt), 0);

    for (int i = 0; i < 8; i++) begin
      doReset();
      applyStimulus(vecs[i].high, 24);
      checkOutput($sformatf("vec%0d rb count", i), rb_q.size(), vecs[i].exp_rolls);
      if (rb_q.size() > 0) begin
        rec = rb_q[0];
        checkSum($sformatf("vec%0d sum at rb", i), int'(rec.sum), vecs[i].exp_sum);
        checkOutput($sformatf("vec%0d die_a at rb", i), int'(rec.a), vecs[i].exp_a);
      end
      checkOutput($sformatf("vec%0d idle die_a", i), int'(die_a), vecs[i].exp_a);
      checkDieB($sformatf("vec%0d idle die_b", i), int'(die_b), vecs[i].exp_b);
      if (vecs[i].exp_rolls == 0) begin
        checkOutput($sformatf("vec%0d idle sum", i), int'(sum), 0);
      end else begin
        checkSum($sformatf("vec%0d idle sum", i), int'(sum), vecs[i].exp_sum);
      end
      checkOutput($sformatf("vec%0d busy", i), int'(busy), 0);
      checkOutput($sformatf("vec%0d roll_cnt", i), int'(roll_cnt), vecs[i].exp_rolls);
    end

    // The rb pulse lasts one cycle and busy drops in the following cycle.
    doReset();
    btn_raw = 1'b1;
    repeat (6) @(negedge clk);
    btn_raw = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rb === 1'b1) got = 1;
    end
    checkOutput("pulse rb seen", got, 1);
    checkSum("pulse sum", int'(sum), 5);
    checkOutput("pulse busy during rb", int'(busy), 1);
    @(negedge clk);
    checkOutput("pulse rb width", int'(rb), 0);
    checkOutput("pulse busy after rb", int'(busy), 0);

    // Reset in the middle of a spin, after 5 advances.
    doReset();
    btn_raw = 1'b1;
    for (int i = 0; i < 30 && !busy; i++) @(negedge clk);
    checkOutput("midspin busy seen", int'(busy), 1);
    repeat (5) @(negedge clk);
    checkOutput("midspin die_a before rst", int'(die_a), 6);
    rst     = 1'b1;
    btn_raw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midspin rst die_a", int'(die_a), 1);
    checkOutput("midspin rst die_b", int'(die_b), 1);
    checkOutput("midspin rst sum", int'(sum), 0);
    checkOutput("midspin rst busy", int'(busy), 0);
    checkOutput("midspin rst rb", int'(rb), 0);
    repeat (30) @(negedge clk);
    checkOutput("midspin no rb after rst", rb_q.size(), 0);
    checkOutput("midspin roll_cnt", int'(roll_cnt), 0);

    // Re-press timed to land in SETTLE and held through PRESENT into IDLE.
    // Holding the button must not start a second roll; a new press must.
    doReset();
    btn_raw = 1'b1;
    repeat (5) @(negedge clk);
    btn_raw = 1'b0;
    repeat (5) @(negedge clk);
    btn_raw = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("hold rb count", rb_q.size(), 1);
    checkOutput("hold busy", int'(busy), 0);
    checkOutput("hold die_a frozen", int'(die_a), 3);
    btn_raw = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(5, 24);
    checkOutput("repress rb count", rb_q.size(), 2);
    checkOutput("repress die_a", int'(die_a), 5);
    checkDieB("repress die_b", int'(die_b), 3);
    checkSum("repress sum", int'(sum), 8);
    checkOutput("repress roll_cnt", int'(roll_cnt), 2);

    // Random press/gap timings checked against the roll-level model.
    doReset();
    n     = 0;
    rolls = 0;
    for (int k = 0; k < 150; k++) begin
      high = $urandom_range(20, 1);
      gap  = $urandom_range(24, 16);
      rb_q.delete();
      applyStimulus(high, gap);
      if (high >= 4) begin
        adv = (high - 1 > 8) ? high - 1 : 8;
        n += adv;
        rolls++;
        checkOutput($sformatf("rand%0d rb count", k), rb_q.size(), 1);
        if (rb_q.size() > 0) begin
          rec = rb_q[0];
          checkOutput($sformatf("rand%0d die_a", k), int'(rec.a), (n % 6) + 1);
          checkDieB($sformatf("rand%0d die_b", k), int'(rec.b), ((n / 6) % 6) + 1);
          checkSum($sformatf("rand%0d sum", k), int'(rec.sum),
                   (n % 6) + 1 + ((n / 6) % 6) + 1);
        end
      end else begin
        checkOutput($sformatf("rand%0d glitch rb count", k), rb_q.size(), 0);
      end
      checkOutput($sformatf("rand%0d roll_cnt", k), int'(roll_cnt), rolls % 256);
    end

    // Top up to 256 completed rolls; the counter must have wrapped to 0.
    while (rolls < 256) begin
      applyStimulus(5, 20);
      rolls++;
      n += 8;
    end
    checkOutput("wrap roll_cnt", int'(roll_cnt), 0);
    checkOutput("wrap die_a", int'(die_a), (n % 6) + 1);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/dice_roll_gen.md
Name: dice_roll_gen

Overview:
- Upstream stage of the dual-dice game controller.
- Conditions the raw roll push-button: 2-flop synchroniser followed by a debouncer.
- Spins two 1..6 dice counters while the button is held, enforcing a minimum spin time.
- On release, freezes the dice and presents a stable 4-bit sum with a one-cycle rb pulse, which the controller samples as its rb/sum inputs.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronised button must differ from the debounced level before that level flips.
- MIN_SPIN, 8: minimum number of dice advances per roll.
- CNT_W, 8: width of the roll_cnt statistics counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  1  asynchronous, bouncy push-button, active-high.
- rb  output  1  one-cycle pulse; sum is valid and stable in this cycle.
- sum  output  4  die_a + die_b, range 2..12, held until next SETTLE.
- die_a  output  3  first die value, 1..6.
- die_b  output  3  second die value, 1..6.
- busy  output  1  high in SPIN, SETTLE and PRESENT.
- roll_cnt  output  CNT_W  completed rolls, wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state=IDLE; die_a=1, die_b=1, sum=0, rb=0, busy=0, roll_cnt=0.
  - Synchroniser flops, debounced level btn_db, debounce counter and spin_cnt all cleared.
  - Reset overrides every other event, including mid-SPIN and PRESENT; no rb pulse is emitted after reset.
- Synchroniser: btn_s = btn_raw delayed 2 flops.
- Debounce:
  - Counter increments while btn_s != btn_db.
  - It clears whenever btn_s == btn_db.
  - When it reaches DEBOUNCE_CYCLES, btn_db toggles and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES never change btn_db.
- Edge detect: press = btn_db & ~btn_db_d (one cycle).
- FSM:
  - IDLE: busy=0. If press, go to SPIN with spin_cnt=0. A held button on return to IDLE does not start a roll; a new rising edge is required.
  - SPIN: busy=1. At each cycle start, if spin_cnt>=MIN_SPIN and btn_db=0, go to SETTLE with no advance. Otherwise advance the dice and do spin_cnt+1, saturating at MIN_SPIN. A release before MIN_SPIN keeps spinning until MIN_SPIN advances have completed. While held, spinning is unlimited.
  - SETTLE: dice frozen; sum <= die_a + die_b, zero-extended 3-bit to 4-bit, maximum 12, no overflow. Next state PRESENT.
  - PRESENT: rb=1 for exactly this cycle; roll_cnt increments, wrapping 2^CNT_W-1 -> 0. Next state IDLE.
- Latency: the rb pulse comes exactly 2 cycles after the SPIN exit decision.
- Presses during SETTLE or PRESENT are ignored. Their edge is consumed and not queued.
- Dice advance (default build):
  - die_a steps 1->2->...->6->1.
  - die_b steps one position only in a cycle where die_a wraps 6->1.
  - Dice never hold values 0 or 7.
- sum, die_a and die_b are unchanged in IDLE. sum reads 0 from reset until the first SETTLE.

Optional Feature:
- Macro: DICE_LFSR_MIX_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1.
  - The LFSR steps every cycle in all states, including IDLE, so button timing randomises outcomes.
  - In SPIN, die_b advances in a cycle where lfsr[0]=1, instead of on the die_a wrap. die_a behaviour is unchanged.
- Undefined:
  - No LFSR logic; die_b uses the cascaded wrap rule.
  - Port list is identical in both builds.

Test Plan:
- Default build, after reset: btn_raw high for 6 cycles, then low -> exactly 8 advances -> die_a=3, die_b=2; one rb pulse with sum=5; roll_cnt=1; busy low the cycle after rb.
- btn_raw held so SPIN makes 13 advances from reset -> die_a=2, die_b=3, sum=5 on rb; dice frozen afterwards and identical in IDLE.
- btn_raw glitch high for 3 cycles (less than DEBOUNCE_CYCLES=4) -> btn_db stays 0, no SPIN, rb never asserts, sum stays 0.
- Assert rst for 1 cycle mid-SPIN (5 advances) -> next cycle: IDLE, die_a=1, die_b=1, sum=0, busy=0, no rb pulse; roll_cnt unchanged at 0.
- Button held continuously through PRESENT and back into IDLE -> no second roll until a release then a new press; run 256 rolls -> roll_cnt wraps to 0.
- DICE_LFSR_MIX_EN defined: same stimulus as the first scenario -> die_a=3 still; die_b matches a reference model of LFSR seed 16'hACE1; sum is in 2..12 on every rb over 1000 random-timed presses.
